// File: rtl/f1_reaction.sv
// f1_reaction: reaction-time measurement for the F1 start-light interface.
// Watches the light pattern from the sequencer. It detects lights-out (all
// eight lit, then all dark) and counts timebase ticks until the driver's
// button rises. It also flags jump starts and timeouts.
//
// Ports:
//   clk            clock
//   rst            synchronous active-high reset
//   en             timebase tick, one-cycle pulse; the counter advances only on these
//   led_num[7:0]   current light pattern
//   trigger        driver button (level); the rising edge is the press
//   reaction_time  last measured tick count, held until the next result
//   valid          one-cycle pulse when reaction_time is updated
//   jump_start     high while a jump start is being flagged
//   timeout        set with a timeout result, cleared when the next sequence arms
//   busy           high while armed or timing
//
// state  | meaning
// IDLE   | waiting for a light sequence to begin
// ARMED  | lights sequencing; all_lit records that 8'hFF was seen
// TIMING | lights out, counting ticks until a press or TIMEOUT
// DONE   | result published, waiting for the next sequence
// FAULT  | press before lights-out; held until the lights go dark
module f1_reaction #(
  parameter int unsigned          WIDTH   = 16,
  parameter logic [WIDTH-1:0]     TIMEOUT = WIDTH'(2000)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [7:0]       led_num,
  input  logic             trigger,
  output logic [WIDTH-1:0] reaction_time,
  output logic             valid,
  output logic             jump_start,
  output logic             timeout,
  output logic             busy
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] ARMED  = 3'd1;
  localparam logic [2:0] TIMING = 3'd2;
  localparam logic [2:0] DONE   = 3'd3;
  localparam logic [2:0] FAULT  = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rt_q, rt_d;
  logic             all_lit_q, all_lit_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;
  logic             trig_q;
  logic             rise;
  logic [WIDTH:0]   cnt_inc;

  assign rise    = trigger & ~trig_q;
  // One bit wider, so that the compare against TIMEOUT cannot wrap.
  assign cnt_inc = {1'b0, cnt_q} + {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rt_d      = rt_q;
    all_lit_d = all_lit_q;
    valid_d   = 1'b0;
    timeout_d = timeout_q;
    case (state_q)
      IDLE: begin
        if (led_num != 8'h00) begin
          state_d   = ARMED;
          all_lit_d = 1'b0;
          timeout_d = 1'b0;
        end
      end
      ARMED: begin
        if (led_num == 8'hFF) all_lit_d = 1'b1;
        // A press in the same cycle the lights go dark is still a jump start.
        if (rise) begin
          state_d = FAULT;
        end else if (led_num == 8'h00) begin
          if (all_lit_q) begin
            state_d = TIMING;
            cnt_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      TIMING: begin
        if (rise) begin
          state_d = DONE;
          rt_d    = cnt_q;
          valid_d = 1'b1;
        end else if (en) begin
          if (cnt_inc == {1'b0, TIMEOUT}) begin
            state_d   = DONE;
            rt_d      = TIMEOUT;
            timeout_d = 1'b1;
            valid_d   = 1'b1;
          end else begin
            cnt_d = cnt_inc[WIDTH-1:0];
          end
        end
      end
      DONE: begin
        if (led_num != 8'h00) begin
          state_d   = ARMED;
          all_lit_d = 1'b0;
          timeout_d = 1'b0;
        end
      end
      FAULT: begin
        if (led_num == 8'h00) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rt_q      <= '0;
      all_lit_q <= 1'b0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      trig_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rt_q      <= rt_d;
      all_lit_q <= all_lit_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      trig_q    <= trigger;
    end
  end

  assign reaction_time = rt_q;
  assign valid         = valid_q;
  assign timeout       = timeout_q;
  assign jump_start    = (state_q == FAULT);
  assign busy          = (state_q == ARMED) || (state_q == TIMING);

endmodule
